// File: rtl/vram_write_ctrl_if.sv
// Bus register port of the VRAM write controller: the master holds W_STB until a
// one-cycle W_ACK pulse, so at most one request is ever outstanding.
interface vram_write_ctrl_if;
  logic [31:0] W_ADDR;
  logic [31:0] W_DAT_I;
  logic        W_STB;
  logic        W_WE;
  logic [31:0] W_DAT_O;
  logic        W_ACK;

  modport master (output W_ADDR, W_DAT_I, W_STB, W_WE, input  W_DAT_O, W_ACK);
  modport slave  (input  W_ADDR, W_DAT_I, W_STB, W_WE, output W_DAT_O, W_ACK);
endinterface

// File: rtl/vram_write_ctrl.sv
// Bus-to-VRAM port B writer: cursor CHAR stores via a small FIFO (write at T+2) plus a full-screen fill engine.
// Backpressure: CHAR/FILL requests stall (ACK withheld) while the FIFO is full or a fill is pending.
module vram_write_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              W_RST,
  vram_write_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data,
  output logic              vram_we,
  output logic              fill_busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;

  localparam logic [1:0] REG_CURSOR = 2'd0;
  localparam logic [1:0] REG_CHAR   = 2'd1;
  localparam logic [1:0] REG_FILL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {IDLE, FILL_WAIT, FILL} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cursor;
  logic [ADDR_W-1:0] fill_cnt;
  logic [DATA_W-1:0] fill_val;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_push;
  logic              fifo_pop;
  logic [ENT_W-1:0]  fifo_head;

  logic [1:0]        sel;
  logic              req;
  logic              cursor_wr;
  logic              char_wr;
  logic              fill_wr;
  logic              blocked;
  logic              accept;
  logic [31:0]       rd_word;
  logic              unused_bits;

  assign sel       = bus.W_ADDR[3:2];
  assign req       = bus.W_STB && !bus.W_ACK;
  assign cursor_wr = bus.W_WE && (sel == REG_CURSOR);
  assign char_wr   = bus.W_WE && (sel == REG_CHAR);
  assign fill_wr   = bus.W_WE && (sel == REG_FILL);

  // CHAR is held off during a fill so queued data can never land on top of it.
  assign blocked = (char_wr && (fifo_full || fill_busy)) || (fill_wr && fill_busy);
  assign accept  = req && !blocked;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_push  = accept && char_wr;
  assign fifo_pop   = !fifo_empty && (state != FILL);
  assign fifo_head  = fifo_mem[rd_ptr];

  assign unused_bits = ^{bus.W_ADDR[31:4], bus.W_ADDR[1:0], bus.W_DAT_I};

  always_comb begin
    rd_word = '0;
    case (sel)
      REG_CURSOR: rd_word = 32'(cursor);
      REG_STATUS: rd_word = {28'b0, fifo_empty, fifo_full, fill_busy, 1'b0};
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= {cursor, bus.W_DAT_I[DATA_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (W_RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (W_RST) begin
      state       <= IDLE;
      cursor      <= '0;
      fill_cnt    <= '0;
      fill_val    <= '0;
      fill_busy   <= 1'b0;
      vram_we     <= 1'b0;
      vram_addr   <= '0;
      vram_data   <= '0;
      bus.W_ACK   <= 1'b0;
      bus.W_DAT_O <= '0;
    end else begin
      bus.W_ACK <= accept;
      if (accept && !bus.W_WE) begin
        bus.W_DAT_O <= rd_word;
      end

      if (accept && cursor_wr) begin
        cursor <= bus.W_DAT_I[ADDR_W-1:0];
      end else if (fifo_push) begin
        cursor <= cursor + ADDR_W'(1);
      end

      if (accept && fill_wr) begin
        fill_val <= bus.W_DAT_I[DATA_W-1:0];
      end

      vram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            vram_we   <= 1'b1;
            vram_addr <= fifo_head[ENT_W-1:DATA_W];
            vram_data <= fifo_head[DATA_W-1:0];
          end
          // The only IDLE cycle with fill_busy set is the one carrying the last fill write.
          if (accept && fill_wr) begin
            fill_busy <= 1'b1;
            state     <= FILL_WAIT;
          end else begin
            fill_busy <= 1'b0;
          end
        end
        FILL_WAIT: begin
          if (fifo_pop) begin
            vram_we   <= 1'b1;
            vram_addr <= fifo_head[ENT_W-1:DATA_W];
            vram_data <= fifo_head[DATA_W-1:0];
          end
          if (fifo_empty) begin
            fill_cnt <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          vram_we   <= 1'b1;
          vram_addr <= fill_cnt;
          vram_data <= fill_val;
          fill_cnt  <= fill_cnt + ADDR_W'(1);
          if (&fill_cnt) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_write_ctrl.sv
// Randomized bench for vram_write_ctrl against a queue-based model of the expected VRAM write stream.
module tb_vram_write_ctrl;
  logic        clk = 1'b0;
  logic        W_RST;
  logic [9:0]  vram_addr;
  logic [15:0] vram_data;
  logic        vram_we;
  logic        fill_busy;

  vram_write_ctrl_if bus();

  vram_write_ctrl #(.ADDR_W(10), .DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .W_RST     (W_RST),
    .bus       (bus),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .vram_we   (vram_we),
    .fill_busy (fill_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [25:0] obs_w[$];
  int          obs_c[$];
  int          busy_rise = -1;
  int          busy_fall = -1;
  logic        prev_busy = 1'b0;

  logic [9:0]  m_cursor = '0;
  logic [25:0] exp_w[$];
  int          exp_c[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle label = number of rising edges so far; samples taken 1ns after the edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (vram_we === 1'b1) begin
        obs_w.push_back({vram_addr, vram_data});
        obs_c.push_back(cyc);
      end
      if (fill_busy === 1'b1 && !prev_busy) busy_rise = cyc;
      if (fill_busy !== 1'b1 && prev_busy) busy_fall = cyc;
      prev_busy = (fill_busy === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_xfer(input logic [1:0] sel, input logic we, input logic [31:0] dat,
                          output logic [31:0] rdat, output int acc);
    logic [31:0] addr;
    int n;
    addr       = $urandom;
    addr[3:2]  = sel;
    bus.W_ADDR  = addr;
    bus.W_DAT_I = dat;
    bus.W_WE    = we;
    bus.W_STB   = 1'b1;
    n   = 0;
    acc = -1;
    while (acc < 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.W_ACK === 1'b1) acc = cyc;
    end
    check_val("ack_seen", 32'(bus.W_ACK), 32'd1);
    rdat      = bus.W_DAT_O;
    bus.W_STB = 1'b0;
    bus.W_WE  = 1'b0;
  endtask

  // Model: a CHAR accepted at edge acc is written in cycle acc+1 and advances the cursor.
  task automatic m_char(input logic [15:0] d, input int acc);
    exp_w.push_back({m_cursor, d});
    exp_c.push_back(acc + 1);
    m_cursor = m_cursor + 10'd1;
  endtask

  // Model: a FILL accepted at edge acc (FIFO drained) writes cell i in cycle acc+2+i.
  task automatic m_fill(input logic [15:0] v, input int acc, input int n);
    for (int i = 0; i < n; i++) begin
      exp_w.push_back({10'(i), v});
      exp_c.push_back(acc + 2 + i);
    end
  endtask

  task automatic check_writes(input string tag);
    logic [25:0] w, ow;
    int c, oc, n;
    n = 0;
    while (obs_w.size() < exp_w.size() && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check_val({tag, "_count"}, 32'(obs_w.size()), 32'(exp_w.size()));
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      w  = exp_w.pop_front();
      c  = exp_c.pop_front();
      ow = obs_w.pop_front();
      oc = obs_c.pop_front();
      check_val({tag, "_addr"}, 32'(ow[25:16]), 32'(w[25:16]));
      check_val({tag, "_data"}, 32'(ow[15:0]), 32'(w[15:0]));
      check_val({tag, "_cycle"}, 32'(oc), 32'(c));
    end
    exp_w.delete();
    exp_c.delete();
    obs_w.delete();
    obs_c.delete();
  endtask

  initial begin
    logic [31:0] rd, d, held;
    int acc, s, a1, a2, k;

    bus.W_ADDR  = '0;
    bus.W_DAT_I = '0;
    bus.W_STB   = 1'b0;
    bus.W_WE    = 1'b0;
    W_RST       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ack", 32'(bus.W_ACK), 32'd0);
    check_val("rst_dat_o", bus.W_DAT_O, 32'd0);
    check_val("rst_vram_we", 32'(vram_we), 32'd0);
    check_val("rst_vram_addr", 32'(vram_addr), 32'd0);
    check_val("rst_vram_data", 32'(vram_data), 32'd0);
    check_val("rst_fill_busy", 32'(fill_busy), 32'd0);
    W_RST = 1'b0;

    @(posedge clk);
    #1;
    s = cyc;
    bus_xfer(2'd3, 1'b0, 32'd0, rd, acc);
    check_val("status_idle", rd, 32'h8);
    check_val("ack_latency", 32'(acc), 32'(s + 1));
    @(posedge clk);
    #1;
    check_val("ack_pulse", 32'(bus.W_ACK), 32'd0);

    bus_xfer(2'd0, 1'b1, 32'h5, rd, acc);
    m_cursor = 10'd5;
    bus_xfer(2'd1, 1'b1, 32'h41, rd, acc);
    m_char(16'h41, acc);
    bus_xfer(2'd1, 1'b1, 32'h42, rd, acc);
    m_char(16'h42, acc);
    bus_xfer(2'd0, 1'b0, 32'd0, rd, acc);
    check_val("cursor_after_chars", rd, 32'(m_cursor));
    held = rd;
    bus_xfer(2'd0, 1'b1, 32'd1023, rd, acc);
    check_val("dat_o_hold", rd, held);
    m_cursor = 10'd1023;
    check_writes("char");

    d = $urandom;
    bus_xfer(2'd1, 1'b1, d, rd, acc);
    m_char(d[15:0], acc);
    d = $urandom;
    bus_xfer(2'd1, 1'b1, d, rd, acc);
    m_char(d[15:0], acc);
    bus_xfer(2'd0, 1'b0, 32'd0, rd, acc);
    check_val("cursor_wrap", rd, 32'(m_cursor));
    bus_xfer(2'd1, 1'b0, 32'd0, rd, acc);
    check_val("char_read_zero", rd, 32'd0);
    check_writes("wrap");

    for (int r = 0; r < 6; r++) begin
      d = $urandom;
      bus_xfer(2'd0, 1'b1, d, rd, acc);
      m_cursor = d[9:0];
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) begin
        d = $urandom;
        bus_xfer(2'd1, 1'b1, d, rd, acc);
        m_char(d[15:0], acc);
        if ($urandom_range(0, 2) == 0) begin
          bus_xfer(2'd0, 1'b0, 32'd0, rd, acc);
          check_val("rand_cursor", rd, 32'(m_cursor));
        end
      end
      bus_xfer(2'd3, 1'b0, 32'd0, rd, acc);
      check_val("rand_status", rd, 32'h8);
      check_writes("rand");
    end

    bus_xfer(2'd2, 1'b1, 32'hABCD0020, rd, a1);
    m_fill(16'h0020, a1, 1024);
    bus_xfer(2'd3, 1'b0, 32'd0, rd, acc);
    check_val("status_busy", rd, 32'hA);
    bus_xfer(2'd2, 1'b0, 32'd0, rd, acc);
    check_val("fill_read_zero", rd, 32'd0);
    for (int j = 0; j < 5; j++) begin
      d = $urandom;
      bus_xfer(2'd1, 1'b1, d, rd, acc);
      if (j == 0) check_val("char_blocked_until", 32'(acc), 32'(a1 + 1027));
      m_char(d[15:0], acc);
    end
    check_val("busy_rise", 32'(busy_rise), 32'(a1));
    check_val("busy_fall", 32'(busy_fall), 32'(a1 + 1026));
    check_writes("fill");

    for (int j = 0; j < 3; j++) begin
      d = $urandom;
      bus_xfer(2'd1, 1'b1, d, rd, acc);
      m_char(d[15:0], acc);
    end
    bus_xfer(2'd2, 1'b1, 32'h0, rd, a1);
    m_fill(16'h0000, a1, 1024);
    d = $urandom;
    bus_xfer(2'd2, 1'b1, d, rd, a2);
    check_val("fill2_blocked_until", 32'(a2), 32'(a1 + 1027));
    m_fill(d[15:0], a2, 1024);
    check_writes("fill_pair");

    d = $urandom;
    bus_xfer(2'd2, 1'b1, d, rd, a1);
    m_fill(d[15:0], a1, 501);
    repeat (502) @(posedge clk);
    #1;
    W_RST = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_vram_we", 32'(vram_we), 32'd0);
    check_val("abort_fill_busy", 32'(fill_busy), 32'd0);
    W_RST = 1'b0;
    m_cursor = 10'd0;
    check_writes("abort");
    bus_xfer(2'd0, 1'b0, 32'd0, rd, acc);
    check_val("abort_cursor", rd, 32'd0);
    bus_xfer(2'd3, 1'b0, 32'd0, rd, acc);
    check_val("abort_status", rd, 32'h8);
    d = $urandom;
    bus_xfer(2'd1, 1'b1, d, rd, acc);
    m_char(d[15:0], acc);
    check_writes("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
